// File: rtl/game_pkg.sv
// Shared game constants, peg type and scorer state encoding.
package game_pkg;

  localparam int unsigned COLOR_W   = 3;
  localparam int unsigned NUM_PEGS  = 4;
  localparam int unsigned MAX_TURNS = 8;

  typedef logic [COLOR_W-1:0] peg_t;

  typedef enum logic [1:0] {
    IDLE,
    EXACT,
    COUNT,
    DONE
  } score_state_t;

endpackage

// File: rtl/guess_scorer_if.sv
// Request/result bundle between the guess-entry side and the scorer.
interface guess_scorer_if;
  import game_pkg::*;

  logic       mode;
  logic       score_req;
  peg_t       guess3, guess2, guess1, guess0;
  peg_t       secret3, secret2, secret1, secret0;
  logic [2:0] exact_cnt;
  logic [2:0] partial_cnt;
  logic       score_valid;
  logic       busy;
  logic [3:0] turns_used;
  logic       win;
  logic       game_over;

  modport master (
    output mode, score_req,
    output guess3, guess2, guess1, guess0,
    output secret3, secret2, secret1, secret0,
    input  exact_cnt, partial_cnt, score_valid, busy, turns_used, win, game_over
  );

  modport slave (
    input  mode, score_req,
    input  guess3, guess2, guess1, guess0,
    input  secret3, secret2, secret1, secret0,
    output exact_cnt, partial_cnt, score_valid, busy, turns_used, win, game_over
  );

endinterface

// File: rtl/color_tally.sv
// Counts the unmasked pegs (of four) that carry a given color.
module color_tally
  import game_pkg::*;
(
  input  peg_t       peg3_i,
  input  peg_t       peg2_i,
  input  peg_t       peg1_i,
  input  peg_t       peg0_i,
  input  logic [3:0] mask_i,
  input  peg_t       color_i,
  output logic [2:0] count_o
);

  logic [3:0] hit;

  assign hit = {peg3_i == color_i, peg2_i == color_i,
                peg1_i == color_i, peg0_i == color_i} & ~mask_i;

  // Popcount of the unmasked color hits.
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      count_o = count_o + 3'(hit[i]);
    end
  end

endmodule

// File: rtl/guess_scorer.sv
// Iterative guess scorer: exact matches in one cycle, then partial matches
// one color per cycle; tracks turns, win and game-over.
module guess_scorer
  import game_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  guess_scorer_if.slave  bus
);

  score_state_t           state_q;
  logic [3:0][COLOR_W-1:0] g_q, s_q;
  logic [3:0]             mask_q;
  logic [2:0]             exact_acc_q, partial_acc_q;
  peg_t                   color_q;
  logic [2:0]             exact_cnt_q, partial_cnt_q;
  logic                   score_valid_q;
  logic [3:0]             turns_used_q;
  logic                   win_q, game_over_q;

  logic [3:0] match_d;
  logic [2:0] exact_d;
  logic [2:0] gc, sc, tally_min;
  logic       accept;
  logic       win_d;

  color_tally u_guess_tally (
    .peg3_i (g_q[3]), .peg2_i (g_q[2]), .peg1_i (g_q[1]), .peg0_i (g_q[0]),
    .mask_i (mask_q), .color_i (color_q), .count_o (gc)
  );

  color_tally u_secret_tally (
    .peg3_i (s_q[3]), .peg2_i (s_q[2]), .peg1_i (s_q[1]), .peg0_i (s_q[0]),
    .mask_i (mask_q), .color_i (color_q), .count_o (sc)
  );

  assign accept    = bus.score_req & ~bus.mode & ~game_over_q;
  assign tally_min = (gc < sc) ? gc : sc;
  assign win_d     = win_q | (exact_acc_q == 3'(NUM_PEGS));

  // Per-peg exact-match mask and its popcount.
  always_comb begin
    exact_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      match_d[i] = (g_q[i] == s_q[i]);
      exact_d    = exact_d + 3'(match_d[i]);
    end
  end

  // Scoring FSM with registered results and status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      g_q           <= '0;
      s_q           <= '0;
      mask_q        <= '0;
      exact_acc_q   <= '0;
      partial_acc_q <= '0;
      color_q       <= '0;
      exact_cnt_q   <= '0;
      partial_cnt_q <= '0;
      score_valid_q <= 1'b0;
      turns_used_q  <= '0;
      win_q         <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      score_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            g_q     <= {bus.guess3, bus.guess2, bus.guess1, bus.guess0};
            s_q     <= {bus.secret3, bus.secret2, bus.secret1, bus.secret0};
            state_q <= EXACT;
          end
        end
        EXACT: begin
          mask_q        <= match_d;
          exact_acc_q   <= exact_d;
          partial_acc_q <= '0;
          color_q       <= '0;
          state_q       <= COUNT;
        end
        COUNT: begin
          partial_acc_q <= partial_acc_q + tally_min;
          color_q       <= color_q + 1'b1;
          if (color_q == '1) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          exact_cnt_q   <= exact_acc_q;
          partial_cnt_q <= partial_acc_q;
          score_valid_q <= 1'b1;
          turns_used_q  <= turns_used_q + 4'd1;
          win_q         <= win_d;
          game_over_q   <= win_d | (turns_used_q + 4'd1 == 4'(MAX_TURNS));
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.exact_cnt   = exact_cnt_q;
  assign bus.partial_cnt = partial_cnt_q;
  assign bus.score_valid = score_valid_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.turns_used  = turns_used_q;
  assign bus.win         = win_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Bench for guess_scorer: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a transaction model.
module tb_guess_scorer;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  guess_scorer_if bus();

  guess_scorer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Mastermind score from color histograms: partial = sum(min) - exact.
  function automatic void score_model(input logic [11:0] g, input logic [11:0] s,
                                      output int ex, output int pa);
    int hg[8];
    int hs[8];
    int total;
    for (int c = 0; c < 8; c++) begin hg[c] = 0; hs[c] = 0; end
    ex = 0;
    total = 0;
    for (int i = 0; i < 4; i++) begin
      if (g[3*i +: 3] == s[3*i +: 3]) ex++;
      hg[g[3*i +: 3]]++;
      hs[s[3*i +: 3]]++;
    end
    for (int c = 0; c < 8; c++) total += (hg[c] < hs[c]) ? hg[c] : hs[c];
    pa = total - ex;
  endfunction

  // Transaction-level model: a request starts a 10-edge countdown.
  int m_rem = 0, m_exact = 0, m_partial = 0, m_turns = 0;
  int pend_e = 0, pend_p = 0;
  bit m_valid = 0, m_win = 0, m_go = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem = 0; m_exact = 0; m_partial = 0; m_turns = 0;
      m_valid = 0; m_win = 0; m_go = 0;
    end else begin
      m_valid = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_exact   = pend_e;
          m_partial = pend_p;
          m_turns++;
          if (pend_e == 4) m_win = 1;
          if (m_win || m_turns == 8) m_go = 1;
          m_valid = 1;
        end
      end else if (bus.score_req && !bus.mode && !m_go) begin
        score_model({bus.guess3, bus.guess2, bus.guess1, bus.guess0},
                    {bus.secret3, bus.secret2, bus.secret1, bus.secret0},
                    pend_e, pend_p);
        m_rem = 10;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("exact_cnt",   int'(bus.exact_cnt),   m_exact);
    check("partial_cnt", int'(bus.partial_cnt), m_partial);
    check("score_valid", int'(bus.score_valid), int'(m_valid));
    check("busy",        int'(bus.busy),        int'(m_rem != 0));
    check("turns_used",  int'(bus.turns_used),  m_turns);
    check("win",         int'(bus.win),         int'(m_win));
    check("game_over",   int'(bus.game_over),   int'(m_go));
  end

  task automatic set_code(input int g3, g2, g1, g0, s3, s2, s1, s0);
    bus.guess3 = 3'(g3);  bus.guess2 = 3'(g2);  bus.guess1 = 3'(g1);  bus.guess0 = 3'(g0);
    bus.secret3 = 3'(s3); bus.secret2 = 3'(s2); bus.secret1 = 3'(s1); bus.secret0 = 3'(s0);
  endtask

  task automatic pulse_req();
    @(negedge clk); #1 bus.score_req = 1'b1;
    @(posedge clk); #1 bus.score_req = 1'b0;
  endtask

  // Cycles from the accepting edge to the first visible score_valid; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.score_valid) begin lat = n; break; end
    end
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (bus.score_valid) cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
  endtask

  task automatic check_result(input string tag, input int e, p, w, g, t);
    check({tag, "_exact"},   int'(bus.exact_cnt),   e);
    check({tag, "_partial"}, int'(bus.partial_cnt), p);
    check({tag, "_win"},     int'(bus.win),         w);
    check({tag, "_over"},    int'(bus.game_over),   g);
    check({tag, "_turns"},   int'(bus.turns_used),  t);
  endtask

  initial begin
    int lat;
    int cnt;
    bus.mode = 1'b0;
    bus.score_req = 1'b0;
    set_code(0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
    check_result("reset", 0, 0, 0, 0, 0);

    // Winning guess.
    set_code(1, 2, 3, 4, 1, 2, 3, 4);
    pulse_req(); wait_valid(lat);
    check("win_latency", lat, 10);
    check_result("win", 4, 0, 1, 1, 1);
    do_reset();

    // All partial, then mixed duplicates, then no hits.
    set_code(4, 3, 2, 1, 1, 2, 3, 4);
    pulse_req(); wait_valid(lat);
    check("perm_latency", lat, 10);
    check_result("perm", 0, 4, 0, 0, 1);
    set_code(1, 2, 1, 1, 1, 1, 2, 2);
    pulse_req(); wait_valid(lat);
    check_result("dup", 1, 2, 0, 0, 2);
    set_code(0, 0, 0, 0, 1, 1, 2, 2);
    pulse_req(); wait_valid(lat);
    check_result("none", 0, 0, 0, 0, 3);
    do_reset();

    // Eight losing guesses exhaust the game; a ninth is ignored.
    set_code(7, 7, 7, 7, 1, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      pulse_req(); wait_valid(lat);
      check("turn_latency", lat, 10);
      check_result("turn", 0, 0, 0, (i == 7) ? 1 : 0, i + 1);
    end
    set_code(1, 2, 3, 4, 1, 2, 3, 4);
    pulse_req(); count_valids(15, cnt);
    check("after_over_valids", cnt, 0);
    check_result("after_over", 0, 0, 0, 1, 8);
    do_reset();

    // Back-to-back request while busy yields a single score.
    set_code(4, 3, 2, 1, 1, 2, 3, 4);
    pulse_req(); pulse_req(); count_valids(25, cnt);
    check("busy_req_valids", cnt, 1);
    check_result("busy_req", 0, 4, 0, 0, 1);

    // Request in browse mode is ignored.
    bus.mode = 1'b1;
    pulse_req(); count_valids(15, cnt);
    check("mode_valids", cnt, 0);
    bus.mode = 1'b0;

    // Guess changed mid-score does not affect the latched result.
    set_code(4, 3, 2, 1, 1, 2, 3, 4);
    pulse_req();
    repeat (5) @(posedge clk);
    #1 set_code(1, 2, 3, 4, 1, 2, 3, 4);
    count_valids(10, cnt);
    check("latch_valids", cnt, 1);
    check_result("latch", 0, 4, 0, 0, 2);

    // Reset while counting color 4.
    set_code(1, 1, 2, 2, 1, 2, 1, 1);
    pulse_req();
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1 check_result("midreset", 0, 0, 0, 0, 0);
    check("midreset_busy", int'(bus.busy), 0);
    count_valids(2, cnt);
    @(negedge clk); #1 reset = 1'b1;
    begin
      int cnt2;
      count_valids(10, cnt2);
      check("midreset_valids", cnt + cnt2, 0);
    end
    pulse_req(); wait_valid(lat);
    check("fresh_latency", lat, 10);
    check_result("fresh", 1, 2, 0, 0, 1);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      if (m_go && $urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        @(negedge clk); #1 reset = 1'b1;
        continue;
      end
      bus.secret3 = 3'($urandom_range(0, 7)); bus.secret2 = 3'($urandom_range(0, 7));
      bus.secret1 = 3'($urandom_range(0, 7)); bus.secret0 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) == 0) begin
        bus.guess3 = bus.secret3; bus.guess2 = bus.secret2;
        bus.guess1 = bus.secret1; bus.guess0 = bus.secret0;
      end else begin
        bus.guess3 = 3'($urandom_range(0, 3)); bus.guess2 = 3'($urandom_range(0, 3));
        bus.guess1 = 3'($urandom_range(0, 7)); bus.guess0 = 3'($urandom_range(0, 7));
      end
      bus.mode      = ($urandom_range(0, 7) == 0);
      bus.score_req = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); #1 bus.score_req = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
